// File: rtl/dac_wave_player.sv
// DAC waveform playback sequencer on port 2 of the waveform RAM.
// Walks a programmed address window at a programmable rate and drives two DAC channels.
module dac_wave_player #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int DAC_WIDTH  = 14,
  parameter int OFFSET_BIN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic [15:0]           rate_div,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DAC_WIDTH-1:0]  dac_a,
  output logic [DAC_WIDTH-1:0]  dac_b,
  output logic                  sample_stb,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           loop_cnt
);

  localparam logic [DAC_WIDTH-1:0] ZERO_CODE =
    (OFFSET_BIN != 0) ? {1'b1, {(DAC_WIDTH-1){1'b0}}} : '0;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  logic [15:0]           cnt;
  logic [ADDR_WIDTH-1:0] cfg_start;
  logic [ADDR_WIDTH-1:0] cfg_end;
  logic                  cfg_loop;
  logic [15:0]           cfg_div;
  logic [15:0]           eff_div_in;

  // Truncate the 16-bit half-word to the DAC width, optionally flipping to offset binary.
  function automatic logic [DAC_WIDTH-1:0] map_code(input logic [15:0] half);
    logic [DAC_WIDTH-1:0] c;
    c = half[15 -: DAC_WIDTH];
    if (OFFSET_BIN != 0) c[DAC_WIDTH-1] = ~c[DAC_WIDTH-1];
    return c;
  endfunction

  // A divider of 0 would let the address change every cycle and outrun the RAM latency.
  assign eff_div_in = (rate_div == 16'd0) ? 16'd1 : rate_div;

  assign mem_we  = 1'b0;
  assign mem_din = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mem_addr   <= '0;
      cnt        <= '0;
      cfg_start  <= '0;
      cfg_end    <= '0;
      cfg_loop   <= 1'b0;
      cfg_div    <= 16'd1;
      dac_a      <= ZERO_CODE;
      dac_b      <= ZERO_CODE;
      sample_stb <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      loop_cnt   <= '0;
    end else begin
      sample_stb <= 1'b0;
      done       <= 1'b0;
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
        dac_a <= ZERO_CODE;
        dac_b <= ZERO_CODE;
      end else if (start) begin
        // A start always wins over a pending tick, so a restart begins cleanly.
        state     <= RUN;
        busy      <= 1'b1;
        cfg_start <= start_addr;
        cfg_end   <= end_addr;
        cfg_loop  <= loop;
        cfg_div   <= eff_div_in;
        mem_addr  <= start_addr;
        cnt       <= eff_div_in;
        loop_cnt  <= '0;
      end else if (state == RUN) begin
        if (cnt != 16'd0) begin
          cnt <= cnt - 16'd1;
        end else begin
          dac_a      <= map_code(mem_dout[15:0]);
          dac_b      <= map_code(mem_dout[31:16]);
          sample_stb <= 1'b1;
          cnt        <= cfg_div;
          if (mem_addr != cfg_end) begin
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
          end else if (cfg_loop) begin
            mem_addr <= cfg_start;
            if (loop_cnt != 16'hFFFF) loop_cnt <= loop_cnt + 16'd1;
          end else begin
            done     <= 1'b1;
            loop_cnt <= 16'd1;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_wave_player.sv
// Directed testbench for dac_wave_player with a registered-read RAM model on port 2.
module tb_dac_wave_player;

  logic        clk = 1'b0;
  logic        rst, start, stop, loop;
  logic [10:0] start_addr, end_addr;
  logic [15:0] rate_div;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic [13:0] dac_a, dac_b;
  logic        sample_stb, busy, done;
  logic [15:0] loop_cnt;

  logic [31:0] ram [0:2047];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_dout <= ram[mem_addr];

  dac_wave_player #(
    .DATA_WIDTH(32), .ADDR_WIDTH(11), .DAC_WIDTH(14), .OFFSET_BIN(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
    .start_addr(start_addr), .end_addr(end_addr), .rate_div(rate_div),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .dac_a(dac_a), .dac_b(dac_b), .sample_stb(sample_stb), .busy(busy),
    .done(done), .loop_cnt(loop_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Returns the number of clocks until the next strobe (capped at 40).
  task automatic wait_strobe(output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (sample_stb !== 1'b1 && k < 40);
  endtask

  task automatic count_strobes(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      step();
      if (sample_stb === 1'b1) cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (mem_addr !== 11'd0) begin errors++; $display("FAIL reset_addr: got %0h expected 0", mem_addr); end
    checks++; if (busy !== 1'b0 || sample_stb !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got busy=%b stb=%b done=%b expected 0 0 0", busy, sample_stb, done); end
    checks++; if (loop_cnt !== 16'd0) begin errors++; $display("FAIL reset_loop_cnt: got %0h expected 0", loop_cnt); end
    checks++; if (dac_a !== 14'h2000 || dac_b !== 14'h2000) begin errors++; $display("FAIL reset_dac: got %0h/%0h expected 2000/2000", dac_a, dac_b); end
    checks++; if (mem_we !== 1'b0 || mem_din !== 32'd0) begin errors++; $display("FAIL reset_we: got we=%b din=%0h expected 0 0", mem_we, mem_din); end
    rst = 1'b0;
  endtask

  task automatic test_oneshot(input string tag);
    logic [13:0] ea [4];
    logic [13:0] eb [4];
    int k, n;
    ea = '{14'h0000, 14'h3FFF, 14'h2000, 14'h248D};
    eb = '{14'h2000, 14'h2000, 14'h2000, 14'h2001};
    start_addr = 11'd0; end_addr = 11'd3; rate_div = 16'd1; loop = 1'b0;
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_on: got %b expected 1", tag, busy); end
    for (int i = 0; i < 4; i++) begin
      wait_strobe(k);
      checks++; if (k !== 2) begin errors++; $display("FAIL %s_spacing%0d: got %0d expected 2", tag, i, k); end
      checks++; if (dac_a !== ea[i]) begin errors++; $display("FAIL %s_dac_a%0d: got %0h expected %0h", tag, i, dac_a, ea[i]); end
      checks++; if (dac_b !== eb[i]) begin errors++; $display("FAIL %s_dac_b%0d: got %0h expected %0h", tag, i, dac_b, eb[i]); end
      checks++; if (done !== (i == 3)) begin errors++; $display("FAIL %s_done%0d: got %b expected %b", tag, i, done, (i == 3)); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_off: got %b expected 0", tag, busy); end
    checks++; if (loop_cnt !== 16'd1) begin errors++; $display("FAIL %s_loop_cnt: got %0h expected 1", tag, loop_cnt); end
    count_strobes(6, n);
    checks++; if (n !== 0) begin errors++; $display("FAIL %s_idle_strobes: got %0d expected 0", tag, n); end
    checks++; if (dac_a !== 14'h248D) begin errors++; $display("FAIL %s_hold: got %0h expected 248d", tag, dac_a); end
  endtask

  task automatic test_rate();
    logic [13:0] ea [4];
    logic [15:0] divs [2];
    int per [2];
    int k;
    ea = '{14'h0000, 14'h3FFF, 14'h2000, 14'h248D};
    divs = '{16'd0, 16'd4};
    per = '{2, 5};
    for (int c = 0; c < 2; c++) begin
      start_addr = 11'd0; end_addr = 11'd3; rate_div = divs[c]; loop = 1'b0;
      pulse_start();
      for (int i = 0; i < 4; i++) begin
        wait_strobe(k);
        checks++; if (k !== per[c]) begin errors++; $display("FAIL rate%0d_period%0d: got %0d expected %0d", divs[c], i, k, per[c]); end
        checks++; if (dac_a !== ea[i]) begin errors++; $display("FAIL rate%0d_dac_a%0d: got %0h expected %0h", divs[c], i, dac_a, ea[i]); end
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rate%0d_done: got %b expected 1", divs[c], done); end
    end
  endtask

  task automatic test_loop_wrap();
    logic [13:0] ea [4];
    logic [10:0] nxt [4];
    int k;
    ea = '{14'h3000, 14'h1000, 14'h0000, 14'h3FFF};
    nxt = '{11'd2047, 11'd0, 11'd1, 11'd2046};
    start_addr = 11'd2046; end_addr = 11'd1; rate_div = 16'd1; loop = 1'b1;
    pulse_start();
    checks++; if (mem_addr !== 11'd2046) begin errors++; $display("FAIL wrap_first_addr: got %0d expected 2046", mem_addr); end
    for (int i = 0; i < 8; i++) begin
      wait_strobe(k);
      checks++; if (k !== 2) begin errors++; $display("FAIL wrap_spacing%0d: got %0d expected 2", i, k); end
      checks++; if (dac_a !== ea[i % 4]) begin errors++; $display("FAIL wrap_dac_a%0d: got %0h expected %0h", i, dac_a, ea[i % 4]); end
      checks++; if (mem_addr !== nxt[i % 4]) begin errors++; $display("FAIL wrap_addr%0d: got %0d expected %0d", i, mem_addr, nxt[i % 4]); end
      checks++; if (loop_cnt !== 16'((i + 1) / 4)) begin errors++; $display("FAIL wrap_loop_cnt%0d: got %0d expected %0d", i, loop_cnt, (i + 1) / 4); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL wrap_done%0d: got %b expected 0", i, done); end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_stop();
    int g, n;
    start_addr = 11'd0; end_addr = 11'd10; rate_div = 16'd1; loop = 1'b0;
    pulse_start();
    g = 0;
    while (mem_addr !== 11'd5 && g < 60) begin
      step();
      g++;
    end
    checks++; if (mem_addr !== 11'd5) begin errors++; $display("FAIL stop_reach_addr5: got %0d expected 5", mem_addr); end
    checks++; if (dac_a !== 14'h3FFF) begin errors++; $display("FAIL stop_pre_dac: got %0h expected 3fff", dac_a); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b expected 0", busy); end
    checks++; if (dac_a !== 14'h2000 || dac_b !== 14'h2000) begin errors++; $display("FAIL stop_dac_zero: got %0h/%0h expected 2000/2000", dac_a, dac_b); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_done: got %b expected 0", done); end
    count_strobes(12, n);
    checks++; if (n !== 0) begin errors++; $display("FAIL stop_strobes: got %0d expected 0", n); end
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_busy: got %b expected 0", busy); end
    count_strobes(8, n);
    checks++; if (n !== 0) begin errors++; $display("FAIL start_stop_strobes: got %0d expected 0", n); end
  endtask

  task automatic test_rewrite();
    logic [13:0] ea [3];
    int k;
    ea = '{14'h3FFF, 14'h2000, 14'h248D};
    start_addr = 11'd0; end_addr = 11'd3; rate_div = 16'd1; loop = 1'b1;
    pulse_start();
    wait_strobe(k);
    start_addr = 11'd2046; end_addr = 11'd2047; rate_div = 16'd4; loop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_strobe(k);
      checks++; if (k !== 2) begin errors++; $display("FAIL rewrite_spacing%0d: got %0d expected 2", i, k); end
      checks++; if (dac_a !== ea[i]) begin errors++; $display("FAIL rewrite_dac_a%0d: got %0h expected %0h", i, dac_a, ea[i]); end
    end
    checks++; if (loop_cnt !== 16'd1 || mem_addr !== 11'd0) begin errors++; $display("FAIL rewrite_old_window: got cnt=%0d addr=%0d expected 1 0", loop_cnt, mem_addr); end
    pulse_start();
    checks++; if (mem_addr !== 11'd2046 || busy !== 1'b1) begin errors++; $display("FAIL restart_addr: got addr=%0d busy=%b expected 2046 1", mem_addr, busy); end
    checks++; if (loop_cnt !== 16'd0) begin errors++; $display("FAIL restart_loop_cnt: got %0d expected 0", loop_cnt); end
    checks++; if (dac_a !== 14'h248D) begin errors++; $display("FAIL restart_dac_held: got %0h expected 248d", dac_a); end
    wait_strobe(k);
    checks++; if (k !== 5 || dac_a !== 14'h3000) begin errors++; $display("FAIL restart_first: got k=%0d a=%0h expected 5 3000", k, dac_a); end
    wait_strobe(k);
    checks++; if (k !== 5 || dac_a !== 14'h1000 || done !== 1'b1) begin errors++; $display("FAIL restart_last: got k=%0d a=%0h done=%b expected 5 1000 1", k, dac_a, done); end
  endtask

  task automatic test_rst_mid();
    int k;
    start_addr = 11'd0; end_addr = 11'd3; rate_div = 16'd1; loop = 1'b1;
    pulse_start();
    repeat (5) wait_strobe(k);
    checks++; if (loop_cnt !== 16'd1) begin errors++; $display("FAIL rst_pre_loop_cnt: got %0d expected 1", loop_cnt); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (mem_addr !== 11'd0 || busy !== 1'b0 || sample_stb !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got addr=%0d busy=%b stb=%b done=%b expected 0 0 0 0", mem_addr, busy, sample_stb, done); end
    checks++; if (loop_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_loop_cnt: got %0d expected 0", loop_cnt); end
    checks++; if (dac_a !== 14'h2000 || dac_b !== 14'h2000) begin errors++; $display("FAIL rst_mid_dac: got %0h/%0h expected 2000/2000", dac_a, dac_b); end
    test_oneshot("post_rst");
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 32'd0;
    ram[0] = 32'h0001_8000;
    ram[1] = 32'h0002_7FFF;
    ram[2] = 32'h0003_0000;
    ram[3] = 32'h0004_1234;
    for (int i = 4; i <= 10; i++) ram[i] = 32'h7FFF_7FFF;
    ram[2046] = 32'h0000_4000;
    ram[2047] = 32'h0000_C000;
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
    start_addr = 11'd0; end_addr = 11'd0; rate_div = 16'd0;

    test_reset();
    test_oneshot("oneshot");
    test_rate();
    test_loop_wrap();
    test_stop();
    test_rewrite();
    test_rst_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
